// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one sum bit per cycle, LSB first (IDLE -> ADD -> DONE).
// Latency: start accepted at edge k, busy for WIDTH cycles, done pulses after edge k+WIDTH.
// Backpressure: none; start is ignored while busy, and start in the DONE cycle chains an operation.
// Optional feature: define SERIAL_ADDER_OVF_EN to register signed overflow; otherwise overflow is tied to 0.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_x;
  logic [WIDTH-1:0] r_y;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_c_next;
  logic [WIDTH-1:0] w_sum_next;

  // Full-adder slice on the current LSBs; the new sum bit enters at the MSB end
  // so that after WIDTH shifts bit 0 of the operands lands in bit 0 of the sum.
  assign w_s        = r_x[0] ^ r_y[0] ^ r_carry;
  assign w_c_next   = (r_x[0] & r_y[0]) | (r_carry & (r_x[0] ^ r_y[0]));
  assign w_sum_next = {w_s, r_sum[WIDTH-1:1]};

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  // Signed overflow: on the final bit r_carry is the carry into the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == ADD && r_cnt == LAST) begin
      r_ovf <= r_carry ^ w_c_next;
    end
  end
  assign overflow = r_ovf;
`else
  assign overflow = 1'b0;
`endif

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_x      <= '0;
      r_y      <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x     <= X;
            r_y     <= Y;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end
        end
        ADD: begin
          r_x     <= r_x >> 1;
          r_y     <= r_y >> 1;
          r_sum   <= w_sum_next;
          r_carry <= w_c_next;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_result <= w_sum_next;
            r_cout   <= w_c_next;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_x     <= X;
            r_y     <= Y;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ADD;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign result    = r_result;
  assign carry_out = r_cout;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vectors for serial_adder at WIDTH=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected overflow follows SERIAL_ADDER_OVF_EN when it is defined for the build.
module tb_serial_adder;

  localparam int WIDTH = 8;
`ifdef SERIAL_ADDER_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             busy;
  logic             done;
  logic             overflow;

  int n_tests = 0;
  int n_fail  = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .X         (X),
    .Y         (Y),
    .result    (result),
    .carry_out (carry_out),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, limit 200000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start for one cycle; returns at the falling edge
  // after the accepting rising edge (first busy cycle).
  task automatic launch(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    X     = x;
    Y     = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count busy cycles until done, checking busy stays high and outputs hold.
  // With inject set, a second start with new operands is pulsed mid-operation.
  task automatic wait_done(input string tag, input logic [7:0] er, input logic ec,
                           input logic eo, input bit inject);
    logic [7:0] hold_r;
    logic       hold_c;
    logic       hold_o;
    int         cyc;
    bit         ok;
    hold_r = result;
    hold_c = carry_out;
    hold_o = overflow;
    cyc    = 0;
    ok     = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1 || result !== hold_r || carry_out !== hold_c || overflow !== hold_o)
        ok = 1'b0;
      if (inject && cyc == 3) begin
        start = 1'b1;
        X     = 8'd50;
        Y     = 8'd50;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check({tag, "_latency"}, 32'(cyc), 32'(WIDTH));
    check({tag, "_busy_hold"}, 32'(ok), 32'd1);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_carry"}, 32'(carry_out), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic done_falls(input string tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int  quiet;
    bit  seen;
    start = 1'b0;
    X     = '0;
    Y     = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_result", 32'(result), 32'd0);
    check("rst_carry", 32'(carry_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 10 + 5
    launch(8'd10, 8'd5);
    wait_done("add_10_5", 8'd15, 1'b0, 1'b0, 1'b0);
    done_falls("add_10_5");

    // 200 + 100 = 300 -> 44 carry 1; signed -56 + 100 does not overflow
    launch(8'd200, 8'd100);
    wait_done("add_200_100", 8'd44, 1'b1, 1'b0, 1'b0);
    done_falls("add_200_100");

    // 127 + 1: signed wrap to -128
    launch(8'd127, 8'd1);
    wait_done("add_127_1", 8'd128, 1'b0, OVF, 1'b0);
    done_falls("add_127_1");

    // 128 + 128: both unsigned carry and signed overflow
    launch(8'd128, 8'd128);
    wait_done("add_128_128", 8'd0, 1'b1, OVF, 1'b0);
    done_falls("add_128_128");

    // 3 + 4 with an ignored mid-operation start (50 + 50)
    launch(8'd3, 8'd4);
    wait_done("add_3_4", 8'd7, 1'b0, 1'b0, 1'b1);
    // Back-to-back: start during the DONE cycle
    X     = 8'd1;
    Y     = 8'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("chain_busy_no_idle", 32'(busy), 32'd1);
    check("chain_done_low", 32'(done), 32'd0);
    wait_done("chain_1_1", 8'd2, 1'b0, 1'b0, 1'b0);
    done_falls("chain_1_1");

    // Reset in the 4th ADD cycle of 255 + 1
    launch(8'd255, 8'd1);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_carry", 32'(carry_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (quiet = 0; quiet < 12; quiet++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("abort_no_done", 32'(seen), 32'd0);

    // Fresh operation after aborted one
    launch(8'd9, 8'd9);
    wait_done("add_9_9", 8'd18, 1'b0, 1'b0, 1'b0);
    done_falls("add_9_9");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled on clk rising edge.
REQ-005 SHALL have port X  input  WIDTH  augend, captured when start is accepted.
REQ-006 SHALL have port Y  input  WIDTH  addend, captured when start is accepted.
REQ-007 SHALL have port result  output  WIDTH  registered sum X+Y mod 2^WIDTH of the last completed operation.
REQ-008 SHALL have port carry_out  output  1  registered unsigned carry out of the last completed operation.
REQ-009 SHALL have port busy  output  1  high while an addition is in progress.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking result/carry_out valid.
REQ-011 SHALL have port overflow  output  1  signed overflow of the last completed operation (see Configuration).

Function
REQ-012 SHALL implement FSM states IDLE, ADD, DONE.
REQ-013 IDLE: start=1 SHALL latch X, Y into internal shift registers, clear internal carry and bit counter, go to ADD.
REQ-014 ADD: each cycle SHALL compute one sum bit LSB-first, s=x^y^c, c_next=(x&y)|(c&(x^y)), shift s into internal sum register.
REQ-015 ADD SHALL last exactly WIDTH cycles; after the WIDTH-th bit, SHALL copy internal sum to result, final carry to carry_out, go to DONE.
REQ-016 DONE SHALL last exactly one cycle; done=1 only in DONE; then go to IDLE, or to ADD if start=1 in DONE (back-to-back).
REQ-017 Latency: start accepted at edge k -> busy=1 after edges k..k+WIDTH-1, done=1 after edge k+WIDTH for one cycle.
REQ-018 busy SHALL be 1 exactly in ADD; done and busy never both 1.
REQ-019 start while in ADD SHALL be ignored; X, Y changes during ADD SHALL NOT affect the operation in progress.
REQ-020 result, carry_out, overflow SHALL hold previous values throughout ADD and change only on the edge entering DONE.
REQ-021 Operands SHALL be unsigned for carry_out; result wraps modulo 2^WIDTH.

Reset
REQ-022 rst_n=0 SHALL immediately, regardless of clk, force state IDLE, result=0, carry_out=0, overflow=0, busy=0, done=0, counter and internal registers 0.
REQ-023 Reset during ADD SHALL abort the operation; no done pulse SHALL follow deassertion.
REQ-024 After rst_n rises, first start SHALL be accepted on the first rising clk edge with rst_n=1.

Configuration
REQ-025 Macro SERIAL_ADDER_OVF_EN: when defined, overflow SHALL be registered with result as (carry into MSB) XOR (carry out of MSB).
REQ-026 When SERIAL_ADDER_OVF_EN is undefined, overflow SHALL be tied to 0 and no overflow logic SHALL be synthesized; port list is unchanged.

Verification (WIDTH=8)
REQ-027 Reset, then X=10,Y=5, start one cycle -> busy 8 cycles, then done pulse with result=15, carry_out=0, overflow=0.
REQ-028 X=200,Y=100 -> result=44, carry_out=1, overflow=0 (overflow=1 only if macro defined and signed wrap occurs).
REQ-029 With SERIAL_ADDER_OVF_EN: X=127,Y=1 -> result=128, carry_out=0, overflow=1; without macro overflow=0.
REQ-030 X=3,Y=4 start, then start=1 with X=50,Y=50 mid-ADD -> second request ignored, result=7; start in DONE cycle with X=1,Y=1 -> next done gives result=2 with no IDLE cycle between.
REQ-031 Start X=255,Y=1, assert rst_n=0 at 4th ADD cycle -> outputs 0 immediately, no done after release; subsequent X=9,Y=9 -> result=18.
